// File: rtl/conv_collect.sv
// Collects normalised convolution results into a readable buffer.
// Tracks output coordinates, frame max and saturation count.
module conv_collect #(
  parameter int N     = 5,
  parameter int M     = 5,
  parameter int K     = 3,
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pxl_in,
  input  logic        valid_in,
  input  logic        clear,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [7:0]  out_row,
  output logic [7:0]  out_col,
  output logic [7:0]  count,
  output logic [7:0]  max_val,
  output logic [7:0]  sat_cnt,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int OUT_W   = N - K + 1;
  localparam int OUT_H   = M - K + 1;
  localparam int OUT_PIX = OUT_W * OUT_H;
  localparam int AW      = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;
  localparam int DEPTH   = 1 << AW;

  localparam logic [7:0] LAST = 8'(OUT_PIX - 1);
  localparam logic [7:0] WMAX = 8'(OUT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] row_q, row_d;
  logic [7:0] col_q, col_d;
  logic [7:0] max_q, max_d;
  logic [7:0] sat_q, sat_d;
  logic       ovf_q, ovf_d;
  logic [7:0] rd_q, rd_d;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [7:0]       mem_q [DEPTH];

  logic [15:0]   shifted;
  logic          sat_hit;
  logic [7:0]    norm;
  logic          accept;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          rd_in_range;

  // Normalise the incoming result and decode write/read indices.
  always_comb begin
    shifted     = pxl_in >> SHIFT;
    sat_hit     = |shifted[15:8];
    norm        = sat_hit ? 8'hFF : shifted[7:0];
    accept      = valid_in && !clear && (state_q != S_DONE);
    wr_idx      = cnt_q[AW-1:0];
    rd_idx      = rd_addr[AW-1:0];
    rd_in_range = int'(rd_addr) < OUT_PIX;
  end

  // Next-state, counter, flag and read-port logic; clear dominates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    max_d   = max_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    rd_d    = rd_q;

    if (rd_en) begin
      if (!rd_in_range) begin
        rd_d = 8'd0;
      end else if (accept && (wr_idx == rd_idx)) begin
        rd_d = norm;
      end else if (vld_q[rd_idx]) begin
        rd_d = mem_q[rd_idx];
      end else begin
        rd_d = 8'd0;
      end
    end

    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      row_d   = 8'd0;
      col_d   = 8'd0;
      max_d   = 8'd0;
      sat_d   = 8'd0;
      ovf_d   = 1'b0;
      vld_d   = '0;
    end else if (valid_in) begin
      if (state_q == S_DONE) begin
        ovf_d = 1'b1;
      end else begin
        vld_d[wr_idx] = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (sat_hit && (sat_q != 8'hFF)) begin
          sat_d = sat_q + 8'd1;
        end
        if (norm > max_q) begin
          max_d = norm;
        end
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          row_d   = 8'd0;
          col_d   = 8'd0;
        end else begin
          state_d = S_COLLECT;
          if (col_q == WMAX) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
      max_q   <= 8'd0;
      sat_q   <= 8'd0;
      ovf_q   <= 1'b0;
      vld_q   <= '0;
      rd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      max_q   <= max_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      rd_q    <= rd_d;
    end
  end

  // Result storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_q[wr_idx] <= norm;
    end
  end

  assign rd_data  = rd_q;
  assign out_row  = row_q;
  assign out_col  = col_q;
  assign count    = cnt_q;
  assign max_val  = max_q;
  assign sat_cnt  = sat_q;
  assign busy     = (state_q == S_COLLECT);
  assign done     = (state_q == S_DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_conv_collect.sv
// Self-checking bench for conv_collect.
// Directed scenarios plus random traffic against a frame model.
module tb_conv_collect;

  localparam int N     = 5;
  localparam int M     = 5;
  localparam int K     = 3;
  localparam int SHIFT = 2;
  localparam int OW    = N - K + 1;
  localparam int PIX   = OW * (M - K + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pxl_in;
  logic        valid_in;
  logic        clear;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  out_row;
  logic [7:0]  out_col;
  logic [7:0]  count;
  logic [7:0]  max_val;
  logic [7:0]  sat_cnt;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  conv_collect #(.N(N), .M(M), .K(K), .SHIFT(SHIFT)) dut (
    .clk(clk),
    .reset(reset),
    .pxl_in(pxl_in),
    .valid_in(valid_in),
    .clear(clear),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_row(out_row),
    .out_col(out_col),
    .count(count),
    .max_val(max_val),
    .sat_cnt(sat_cnt),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  logic [50:0] dut_vec;
  assign dut_vec = {out_row, out_col, count, max_val, sat_cnt,
                    busy, done, overflow, rd_data};

  // Frame model: results list, valid flags and summary figures.
  int         m_cnt;
  logic [7:0] m_mem [256];
  bit         m_vld [256];
  logic [7:0] m_max;
  logic [7:0] m_sat;
  logic [7:0] m_rd;
  bit         m_ovf;
  bit         m_done;

  function automatic logic [7:0] f_norm(input logic [15:0] p);
    int v;
    v = int'(p) >> SHIFT;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic model_reset_frame();
    m_cnt = 0;
    m_max = 0;
    m_sat = 0;
    m_ovf = 0;
    m_done = 0;
    for (int i = 0; i < 256; i++) m_vld[i] = 0;
  endtask

  task automatic model_edge();
    logic [7:0] nrm;
    bit acc;
    if (reset) begin
      model_reset_frame();
      m_rd = 0;
      return;
    end
    nrm = f_norm(pxl_in);
    acc = valid_in && !clear && !m_done;
    if (rd_en) begin
      if (int'(rd_addr) >= PIX) m_rd = 0;
      else if (acc && int'(rd_addr) == m_cnt) m_rd = nrm;
      else m_rd = m_vld[rd_addr] ? m_mem[rd_addr] : 8'd0;
    end
    if (clear) begin
      model_reset_frame();
    end else if (valid_in) begin
      if (m_done) begin
        m_ovf = 1;
      end else begin
        m_mem[m_cnt] = nrm;
        m_vld[m_cnt] = 1;
        m_cnt++;
        if ((int'(pxl_in) >> SHIFT) > 255 && m_sat != 8'd255) m_sat++;
        if (nrm > m_max) m_max = nrm;
        if (m_cnt == PIX) m_done = 1;
      end
    end
  endtask

  function automatic logic [50:0] exp_vec();
    logic [7:0] r;
    logic [7:0] c;
    logic       b;
    r = m_done ? 8'd0 : 8'(m_cnt / OW);
    c = m_done ? 8'd0 : 8'(m_cnt % OW);
    b = !m_done && (m_cnt > 0);
    return {r, c, 8'(m_cnt), m_max, m_sat, b, m_done, m_ovf, m_rd};
  endfunction

  task automatic cyc(input logic v, input logic [15:0] p,
                     input logic c, input logic re,
                     input logic [7:0] ra, input logic rs);
    valid_in = v;
    pxl_in   = p;
    clear    = c;
    rd_en    = re;
    rd_addr  = ra;
    reset    = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    n_tests++;
    if (dut_vec !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", dut_vec);
    end
    idle();
  endtask

  task automatic test_basic();
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < PIX; i++) begin
      cyc(1'b1, 16'(4 * (i + 1)), 1'b0, 1'b0, 8'd0, 1'b0);
      n_tests++;
      if (done !== (i == PIX - 1)) begin
        n_fail++;
        $display("FAIL basic_done[%0d]: got %b expected %b",
                 i, done, (i == PIX - 1));
      end
    end
    n_tests++;
    if (count !== 8'd9 || max_val !== 8'd9 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_summary: got cnt=%0d max=%0d busy=%b expected 9 9 0",
               count, max_val, busy);
    end
    for (int i = 0; i < PIX; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'(i), 1'b0);
      n_tests++;
      if (rd_data !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL basic_read[%0d]: got %0d expected %0d",
                 i, rd_data, i + 1);
      end
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL basic_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 8'd0, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || count !== 8'd9 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf=%b cnt=%0d done=%b expected 1 9 1",
               overflow, count, done);
    end
    for (int i = 0; i < PIX; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'(i), 1'b0);
      n_tests++;
      if (rd_data !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL overflow_buf[%0d]: got %0d expected %0d",
                 i, rd_data, i + 1);
      end
    end
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    n_tests++;
    if (done !== 1'b0 || overflow !== 1'b0 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL overflow_clear: got done=%b ovf=%b cnt=%0d expected 0 0 0",
               done, overflow, count);
    end
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'd0, 1'b0);
    n_tests++;
    if (rd_data !== 8'd0) begin
      n_fail++;
      $display("FAIL overflow_rd0: got %0d expected 0", rd_data);
    end
  endtask

  task automatic test_saturation();
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 16'd1020, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 16'd1024, 1'b0, 1'b0, 8'd0, 1'b0);
    n_tests++;
    if (sat_cnt !== 8'd1 || max_val !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_count: got sat=%0d max=%0d expected 1 255",
               sat_cnt, max_val);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'(i), 1'b0);
      n_tests++;
      if (rd_data !== 8'd255) begin
        n_fail++;
        $display("FAIL sat_read[%0d]: got %0d expected 255", i, rd_data);
      end
    end
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b1, 8'd2, 1'b0);
    n_tests++;
    if (rd_data !== 8'd255 || sat_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL sat_bypass: got rd=%0d sat=%0d expected 255 2",
               rd_data, sat_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 16'($urandom_range(4, 65535)), 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    n_tests++;
    if (dut_vec !== 51'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got %h expected 0", dut_vec);
    end
    cyc(1'b1, 16'd40, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'd0, 1'b0);
    n_tests++;
    if (rd_data !== 8'd10 || count !== 8'd1) begin
      n_fail++;
      $display("FAIL midreset_addr0: got rd=%0d cnt=%0d expected 10 1",
               rd_data, count);
    end
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'd4, 1'b0);
    n_tests++;
    if (rd_data !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_addr4: got %0d expected 0", rd_data);
    end
  endtask

  task automatic test_gapped();
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < PIX; i++) begin
      n_tests++;
      if (out_row !== 8'(i / OW) || out_col !== 8'(i % OW)) begin
        n_fail++;
        $display("FAIL gapped_pos[%0d]: got %0d/%0d expected %0d/%0d",
                 i, out_row, out_col, i / OW, i % OW);
      end
      cyc(1'b1, 16'($urandom_range(4, 65535)), 1'b0, 1'b0, 8'd0, 1'b0);
      idle();
      idle();
    end
    n_tests++;
    if (out_row !== 8'd0 || out_col !== 8'd0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL gapped_end: got %0d/%0d done=%b expected 0/0 1",
               out_row, out_col, done);
    end
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'd0, 1'b0);
    cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'd9, 1'b0);
    n_tests++;
    if (rd_data !== 8'd0) begin
      n_fail++;
      $display("FAIL gapped_addr9: got %0d expected 0", rd_data);
    end
  endtask

  task automatic test_clear_collide();
    cyc(1'b0, 16'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'($urandom_range(4, 65535)), 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 16'd200, 1'b1, 1'b0, 8'd0, 1'b0);
    n_tests++;
    if (busy !== 1'b0 || count !== 8'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_state: got busy=%b cnt=%0d done=%b expected 0 0 0",
               busy, count, done);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'd0, 1'b0, 1'b1, 8'(i), 1'b0);
      n_tests++;
      if (rd_data !== 8'd0) begin
        n_fail++;
        $display("FAIL collide_read[%0d]: got %0d expected 0", i, rd_data);
      end
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        c;
    logic        rs;
    logic        re;
    logic [15:0] p;
    int          r;
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 99);
      rs = (r < 2);
      c  = !rs && (r < 6);
      v  = ($urandom_range(0, 2) != 0);
      p  = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                       : 16'($urandom_range(0, 1100));
      re = !c && ($urandom_range(0, 1) == 1);
      cyc(v, p, c, re, 8'($urandom_range(0, 11)), rs);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h",
                 n, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = 16'd0;
    clear    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = 8'd0;
    m_rd     = 8'd0;
    model_reset_frame();
    test_reset();
    test_basic();
    test_overflow();
    test_saturation();
    test_reset_mid();
    test_gapped();
    test_clear_collide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_collect.md
CONV_COLLECT -- requirements
Module: conv_collect

Interface
REQ-001 Parameter N, default 5: image columns of the upstream convolution.
REQ-002 Parameter M, default 5: image rows of the upstream convolution.
REQ-003 Parameter K, default 3: kernel size; OUT_W = N-K+1 and OUT_H = M-K+1 SHALL be derived; OUT_PIX = OUT_W*OUT_H.
REQ-004 Parameter SHIFT, default 2: right-shift normalisation applied to each result.
REQ-005 Clock and reset SHALL be exactly as decided: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 pxl_in  in  16  convolution result from the upstream conv stage.
REQ-009 valid_in  in  1  pxl_in qualifier, one result per cycle when high.
REQ-010 clear  in  1  single-cycle request to discard the frame and rearm.
REQ-011 rd_en  in  1  read strobe for the result buffer.
REQ-012 rd_addr  in  8  raster index of the result to read.
REQ-013 rd_data  out  8  normalised result, registered.
REQ-014 out_row  out  8  row of the next result to be written.
REQ-015 out_col  out  8  column of the next result to be written.
REQ-016 count  out  8  number of results stored in the current frame.
REQ-017 max_val  out  8  largest normalised result in the current frame.
REQ-018 sat_cnt  out  8  number of saturated results in the current frame.
REQ-019 busy  out  1  high in COLLECT.
REQ-020 done  out  1  high in DONE.
REQ-021 overflow  out  1  sticky flag for valid_in received in DONE.

Function
REQ-022 The FSM SHALL have three states: IDLE, COLLECT and DONE.
- IDLE->COLLECT on valid_in.
- COLLECT->DONE on the valid_in that stores result OUT_PIX-1.
- DONE->IDLE on clear.
- clear in any state SHALL go to IDLE and zero count, out_row, out_col, max_val, sat_cnt, overflow and all entry-valid bits.
REQ-023 Every result accepted in IDLE or COLLECT SHALL be stored the same cycle at index count. The stored value is norm = min(pxl_in >> SHIFT, 255) as an unsigned 8-bit value.
REQ-024 When (pxl_in >> SHIFT) > 255, norm SHALL be 255 and sat_cnt SHALL increment, saturating at 255.
REQ-025 max_val SHALL update to norm when norm > max_val.
REQ-026 On each stored result, out_col SHALL increment; on reaching OUT_W-1 it SHALL wrap to 0 and out_row SHALL increment. After the last result, out_row and out_col SHALL hold at 0.
REQ-027 valid_in with clear in the same cycle: clear wins and the result is discarded.
REQ-028 valid_in in DONE SHALL be ignored, with no buffer or counter change, and SHALL set overflow.
REQ-029 Each buffer entry SHALL carry a valid bit, set on write.
REQ-030 rd_data SHALL appear one cycle after rd_en and hold its value otherwise.
- rd_data SHALL be 0 when rd_addr >= OUT_PIX or the entry valid bit is clear.
REQ-031 Reads SHALL be allowed in any state.
- A read and a write to the same index in the same cycle SHALL return the newly written value.
REQ-032 Arithmetic SHALL be unsigned, with no sign extension of pxl_in.

Reset
REQ-033 On reset the FSM SHALL enter IDLE with all outputs 0.
- This covers rd_data, out_row, out_col, count, max_val, sat_cnt, busy, done and overflow.
- All entry-valid bits SHALL be cleared.
REQ-034 Reset asserted mid-COLLECT SHALL abandon the partial frame; the next valid_in after release SHALL be stored at index 0.

Verification
REQ-035 Nine valid_in pulses with pxl_in = 4,8,...,36 (SHIFT=2) -> done after the 9th; count=9; rd_addr 0..8 return 1..9; max_val=9.
REQ-036 pxl_in = 1020 then 1024 -> stored values 255 and 255; sat_cnt=1.
REQ-037 Tenth valid_in after done -> overflow=1, count stays 9, buffer unchanged; clear -> done=0, overflow=0, rd_data(0)=0.
REQ-038 Reset after 4 results -> all outputs 0; the next result is readable at addr 0; addr 4 reads 0.
REQ-039 Gapped valid_in (1 on / 2 off) -> out_row/out_col step 0/0, 0/1, 0/2, 1/0, ...; rd_addr 9 -> 0.
REQ-040 valid_in and clear in the same cycle during COLLECT -> IDLE, count=0, result not stored.
